// File: rtl/cpu.sv
// Minimal 16-bit multi-cycle accumulator CPU (A, B, PC, OP) on a shared memory bus.
// Every instruction runs FETCH -> EXECUTE -> [LOAD] -> ALU; all bus outputs are registered.
module cpu #(
    parameter int unsigned FETCH_IDLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] address,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    output logic        wren_n,
    output logic        oen_n
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        EXECUTE = 3'd1,
        LOAD    = 3'd2,
        ALU     = 3'd3
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_OR   = 3'd2,
        ALU_AND  = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_B    = 3'd5,
        ALU_A    = 3'd6,
        ALU_ZERO = 3'd7
    } alu_op_t;

    localparam logic [3:0] IDLE_INIT = 4'(FETCH_IDLE);

    state_t      state, state_d;
    logic [3:0]  counter, counter_d;
    logic [15:0] pc, pc_d;
    logic [15:0] a, a_d;
    logic [15:0] b, b_d;
    logic [15:0] op, op_d;
    logic [15:0] address_d, data_out_d;
    logic        wren_n_d, oen_n_d;

    alu_op_t     alu_sel;
    logic [15:0] alu_res;

    assign alu_sel = alu_op_t'(op[11:9]);

    // Operands are the a/b registers as they stand on ALU entry.
    always_comb begin
        case (alu_sel)
            ALU_ADD:  alu_res = a + b;
            ALU_SUB:  alu_res = a - b;
            ALU_OR:   alu_res = a | b;
            ALU_AND:  alu_res = a & b;
            ALU_XOR:  alu_res = a ^ b;
            ALU_B:    alu_res = b;
            ALU_A:    alu_res = a;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            counter  <= IDLE_INIT;
            pc       <= '0;
            a        <= '0;
            b        <= '0;
            op       <= '0;
            address  <= '0;
            data_out <= '0;
            wren_n   <= 1'b1;
            oen_n    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state    <= state_d;
            counter  <= counter_d;
            pc       <= pc_d;
            a        <= a_d;
            b        <= b_d;
            op       <= op_d;
            address  <= address_d;
            data_out <= data_out_d;
            wren_n   <= wren_n_d;
            oen_n    <= oen_n_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state;
        counter_d  = counter;
        pc_d       = pc;
        a_d        = a;
        b_d        = b;
        op_d       = op;
        address_d  = address;
        data_out_d = data_out;
        wren_n_d   = 1'b1;
        oen_n_d    = 1'b1;

        case (state)
            FETCH: begin
                if (counter != 4'd0) begin
                    counter_d = counter - 4'd1;
                    // Drive the fetch read so it is on the bus during the counter==0 cycle.
                    if (counter == 4'd1) begin
                        address_d = pc;
                        oen_n_d   = 1'b0;
                    end
                end else begin
                    op_d    = data_in;
                    state_d = EXECUTE;
                end
            end

            EXECUTE: begin
                counter_d = 4'd0;
                casez (op[15:13])
                    3'b00?: begin
                        b_d     = {2'b00, op[13:0]};
                        state_d = ALU;
                    end
                    3'b010: begin
                        address_d  = b;
                        data_out_d = a;
                        wren_n_d   = 1'b0;
                        state_d    = ALU;
                    end
                    3'b011: begin
                        address_d = b;
                        oen_n_d   = 1'b0;
                        state_d   = LOAD;
                    end
                    3'b11?: begin
                        b_d     = {{8{op[7]}}, op[7:0]};
                        state_d = ALU;
                    end
                    default: begin
                        state_d = ALU;
                    end
                endcase
            end

            LOAD: begin
                // The read stays enabled through the following ALU cycle.
                b_d     = data_in;
                oen_n_d = 1'b0;
                state_d = ALU;
            end

            ALU: begin
                pc_d = pc + 16'd1;
                if (op[15]) begin
                    if (op[13]) a_d  = alu_res;
                    if (op[12]) b_d  = alu_res;
                    if (op[8])  pc_d = alu_res;
                end
                counter_d = IDLE_INIT;
                state_d   = FETCH;
            end

            default: begin
                counter_d = IDLE_INIT;
                state_d   = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed programs plus random memory images, each instruction
// compared against an instruction-level model of the accumulator machine.
module tb_cpu;

    localparam int unsigned IDLE = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] address;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        wren_n;
    logic        oen_n;

    logic [15:0] mem   [0:65535];
    logic [15:0] m_mem [0:65535];
    logic [15:0] m_a, m_b, m_pc;

    int checks   = 0;
    int failures = 0;

    cpu #(.FETCH_IDLE(IDLE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .data_out (data_out),
        .data_in  (data_in),
        .wren_n   (wren_n),
        .oen_n    (oen_n)
    );

    always #5 clk = ~clk;

    // Memory answers only while the read strobe is active.
    assign data_in = oen_n ? 16'hDEAD : mem[address];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory write on the edge, then sample on the falling edge.
    task automatic tick();
        logic        do_wr;
        logic [15:0] wr_addr, wr_data;
        do_wr   = !wren_n;
        wr_addr = address;
        wr_data = data_out;
        @(posedge clk);
        if (do_wr) mem[wr_addr] = wr_data;
        @(negedge clk);
        check("strobe_exclusive", 16'(wren_n | oen_n), 16'd1);
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] w;
            w        = rnd ? 16'($urandom) : 16'h0000;
            mem[i]   = w;
            m_mem[i] = w;
        end
    endtask

    task automatic poke(input logic [15:0] addr, input logic [15:0] w);
        mem[addr]   = w;
        m_mem[addr] = w;
    endtask

    function automatic int alu_ref(input int f, input int x, input int y);
        case (f)
            0:       return (x + y) % 65536;
            1:       return (x - y + 65536) % 65536;
            2:       return x | y;
            3:       return x & y;
            4:       return x ^ y;
            5:       return y;
            6:       return x;
            default: return 0;
        endcase
    endfunction

    // Architectural effect of one instruction on the model state.
    task automatic model_step(input logic [15:0] ins);
        int lit;
        int res;
        case (ins[15:14])
            2'b00: m_b = 16'(int'(ins[13:0]));
            2'b01: begin
                if (ins[13]) m_b = m_mem[m_b];
                else         m_mem[m_b] = m_a;
            end
            2'b11: begin
                lit = int'(ins[7:0]);
                if (lit >= 128) lit = lit - 256;
                m_b = 16'((lit + 65536) % 65536);
            end
            default: ;
        endcase
        if (ins[15]) begin
            res = alu_ref(int'(ins[11:9]), int'(m_a), int'(m_b));
            if (ins[13]) m_a = 16'(res);
            if (ins[12]) m_b = 16'(res);
            m_pc = ins[8] ? 16'(res) : 16'((int'(m_pc) + 1) % 65536);
        end else begin
            m_pc = 16'((int'(m_pc) + 1) % 65536);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_state",    16'(dut.state),   16'd0);
        check("rst_counter",  16'(dut.counter), 16'(IDLE));
        check("rst_pc",       dut.pc,           16'h0000);
        check("rst_a",        dut.a,            16'h0000);
        check("rst_b",        dut.b,            16'h0000);
        check("rst_op",       dut.op,           16'h0000);
        check("rst_address",  address,          16'h0000);
        check("rst_data_out", data_out,         16'h0000);
        check("rst_wren_n",   16'(wren_n),      16'd1);
        check("rst_oen_n",    16'(oen_n),       16'd1);
        rst_n = 1'b1;
        m_a  = 16'h0000;
        m_b  = 16'h0000;
        m_pc = 16'h0000;
    endtask

    // Entered on the falling edge inside the first FETCH cycle; leaves at the next one.
    task automatic run_instr();
        logic [15:0] ins, pc0, a0, b0;
        logic        is_load, is_store;
        ins      = m_mem[m_pc];
        pc0      = m_pc;
        a0       = m_a;
        b0       = m_b;
        is_store = (ins[15:13] == 3'b010);
        is_load  = (ins[15:13] == 3'b011);

        check("fetch_state", 16'(dut.state), 16'd0);
        check("fetch_idle",  16'(oen_n),     16'd1);
        repeat (IDLE) tick();
        check("fetch_addr",  address,        pc0);
        check("fetch_oen",   16'(oen_n),     16'd0);
        check("fetch_wren",  16'(wren_n),    16'd1);
        tick();
        check("exec_state",  16'(dut.state), 16'd1);
        check("exec_op",     dut.op,         ins);
        tick();
        if (is_load) begin
            check("load_state", 16'(dut.state), 16'd2);
            check("load_addr",  address,        b0);
            check("load_oen",   16'(oen_n),     16'd0);
            tick();
            check("load_alu_oen", 16'(oen_n), 16'd0);
        end else if (is_store) begin
            check("store_addr", address,      b0);
            check("store_data", data_out,     a0);
            check("store_wren", 16'(wren_n),  16'd0);
            check("store_oen",  16'(oen_n),   16'd1);
        end else begin
            check("alu_wren", 16'(wren_n), 16'd1);
            check("alu_oen",  16'(oen_n),  16'd1);
        end
        check("alu_state", 16'(dut.state), 16'd3);
        model_step(ins);
        tick();
        check("next_state", 16'(dut.state), 16'd0);
        check("next_wren",  16'(wren_n),    16'd1);
        check("next_oen",   16'(oen_n),     16'd1);
        check("reg_pc",     dut.pc,         m_pc);
        check("reg_a",      dut.a,          m_a);
        check("reg_b",      dut.b,          m_b);
        if (is_store) check("store_mem", mem[b0], a0);
    endtask

    initial begin
        rst_n = 1'b0;

        // Directed program walking through each instruction class.
        fill_mem(1'b0);
        poke(16'h0000, 16'h0005);
        poke(16'h0001, 16'hE001);
        poke(16'h0002, 16'h1234);
        poke(16'h0003, 16'hAA00);
        poke(16'h0004, 16'h0100);
        poke(16'h0005, 16'h4000);
        poke(16'h0006, 16'h0020);
        poke(16'h0007, 16'h6000);
        poke(16'h0008, 16'h0010);
        poke(16'h0009, 16'hAA00);
        poke(16'h000A, 16'hCB7F);
        poke(16'h0020, 16'hBEEF);
        poke(16'h007F, 16'h0001);
        poke(16'h0080, 16'hAA00);
        poke(16'h0081, 16'hE080);
        poke(16'h0082, 16'hCBFF);
        poke(16'hFFFF, 16'h0003);
        do_reset();

        run_instr();
        check("lit_b",  dut.b,  16'h0005);
        check("lit_pc", dut.pc, 16'h0001);
        run_instr();
        check("opa_b",  dut.b,  16'h0001);
        check("opa_a",  dut.a,  16'h0001);
        check("opa_pc", dut.pc, 16'h0002);
        repeat (4) run_instr();
        check("store_result", mem[16'h0100], 16'h1234);
        run_instr();
        run_instr();
        check("load_b",     dut.b, 16'hBEEF);
        check("load_a_kept", dut.a, 16'h1234);
        repeat (3) run_instr();
        check("jump_b",  dut.b,  16'h007F);
        check("jump_pc", dut.pc, 16'h007F);
        repeat (3) run_instr();
        check("sext_b", dut.b, 16'hFF80);
        check("sext_a", dut.a, 16'hFF81);
        run_instr();
        check("jump_top", dut.pc, 16'hFFFF);
        run_instr();
        check("pc_wrap", dut.pc, 16'h0000);

        // Reset landing in the write cycle of a store must cancel the write.
        fill_mem(1'b0);
        poke(16'h0000, 16'h0100);
        poke(16'h0001, 16'h4000);
        poke(16'h0100, 16'h5555);
        do_reset();
        run_instr();
        repeat (IDLE + 2) tick();
        check("abort_wren_live", 16'(wren_n), 16'd0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_wren",  16'(wren_n),    16'd1);
        check("abort_oen",   16'(oen_n),     16'd1);
        check("abort_addr",  address,        16'h0000);
        check("abort_state", 16'(dut.state), 16'd0);
        check("abort_pc",    dut.pc,         16'h0000);
        @(negedge clk);
        tick();
        check("abort_no_write", mem[16'h0100], 16'h5555);
        do_reset();
        run_instr();

        // Random memory images executed from reset.
        for (int r = 0; r < 3; r++) begin
            fill_mem(1'b1);
            do_reset();
            for (int n = 0; n < 50; n++) run_instr();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
